sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 DEV_ID, 8'h42, 8-bit write ID (bit0=0); read ID is DEV_ID|1.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 sioc  input  1  SCCB serial clock from the master, asynchronous to clk.
REQ-005 siod_i  input  1  SCCB data line as seen on the pad.
REQ-006 siod_oe  output  1  1 = pull SIOD low (open-drain); 0 = release.
REQ-007 wr_strobe  output  1  one-cycle pulse when a register write commits.
REQ-008 wr_addr  output  8  sub-address of the last committed write.
REQ-009 wr_data  output  8  data of the last committed write.
REQ-010 soft_reset  output  1  one-cycle pulse when COM7 (0x12) is written with bit7=1.
REQ-011 busy  output  1  1 from START detect until STOP detect.

Function
REQ-012 sioc and siod_i SHALL each pass through a 2-flop synchronizer plus one history flop; all events below are derived from synchronized values (3-cycle pin-to-event latency).
REQ-013 START SHALL be a synchronized SIOD 1->0 with SIOC high; STOP SHALL be SIOD 0->1 with SIOC high; both are legal in any state.
REQ-014 Data bits SHALL be sampled on the SIOC rising event; siod_oe SHALL change only on the SIOC falling event, in the same cycle it is detected.
REQ-015 States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNA, IGNORE.
REQ-016 IDLE->ID on START; any state->ID on repeated START; any state->IDLE on STOP with siod_oe=0 in the same cycle.
REQ-017 ID: shift 8 bits MSB first; on the falling SIOC after bit 8: byte==DEV_ID -> ID_ACK (write), byte==DEV_ID|1 -> ID_ACK (read), else IGNORE with siod_oe=0.
REQ-018 Every *_ACK state SHALL assert siod_oe for exactly one SIOC bit period (from the falling event after bit 8 to the next falling event).
REQ-019 Write path: ID_ACK->SUB->SUB_ACK latches the 8-bit sub-address pointer ->WDATA->WDATA_ACK->IGNORE (further bytes are not acknowledged).
REQ-020 Write commit SHALL occur on the falling SIOC event after the 8th data bit: regfile[ptr]<=data, wr_addr/wr_data updated, wr_strobe=1 for that one cycle.
REQ-021 A STOP after SUB_ACK with no data byte SHALL leave ptr set and commit nothing (read-pointer setup).
REQ-022 Read path: ID_ACK->RDATA drives regfile[ptr] MSB first, siod_oe=~bit, each bit applied on a falling event; after bit 8, RNA releases SIOD and ignores the master's bit, then ->IGNORE. ptr SHALL NOT auto-increment.
REQ-023 Register file: 256x8. Defaults are 8'h00 except 0x0A=8'h76 (PID), 0x0B=8'h73 (VER), 0x1C=8'h7F (MIDH), 0x1D=8'hA2 (MIDL).
REQ-024 0x0A, 0x0B, 0x1C and 0x1D SHALL be read-only: writes are ACKed and strobed but the array does not change.
REQ-025 A write of 0x12 with data bit7=1 SHALL, in the commit cycle, restore all 256 entries to defaults (0x12 reads 8'h00 afterward) and pulse soft_reset together with wr_strobe.
REQ-026 IGNORE SHALL keep siod_oe=0 until START or STOP.

Reset
REQ-027 rst_n low SHALL immediately force: state=IDLE, siod_oe=0, wr_strobe=0, soft_reset=0, busy=0, wr_addr=0, wr_data=0, ptr=0, synchronizers to 1, regfile to defaults. This holds also mid-transaction.
REQ-028 After rst_n rises, a bus already mid-byte SHALL be ignored until the next START.

Verification
REQ-029 Write 42/17/11 -> three ACKs; wr_strobe once with wr_addr=8'h17, wr_data=8'h11; a later read of 0x17 returns 8'h11.
REQ-030 Write 42/0A (STOP), then read 43 -> returned byte 8'h76; SIOD released during the NA bit.
REQ-031 ID 8'h60 -> no ACK, siod_oe stays 0 through STOP; no wr_strobe.
REQ-032 Write 42/12/80 after writing 8'h55 to 0x40 -> soft_reset and wr_strobe in the same cycle; a read of 0x40 returns 8'h00 and 0x12 returns 8'h00.
REQ-033 Repeated START during WDATA bit 4, followed by 43 -> no commit; a read byte is returned from the pointer set earlier.
REQ-034 rst_n pulsed low during an ACK bit -> siod_oe drops asynchronously; a transaction started after reset completes normally.

Source files
------------

// File: rtl/sccb_responder.sv
// SCCB (three-wire, I2C-like) responder with a 256x8 register file.
// One byte is committed per write transaction; reads return regfile[ptr] without auto-increment.
module sccb_responder #(
    parameter logic [7:0] DEV_ID = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       soft_reset,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNA, IGNORE
    } state_t;

    localparam logic [7:0] COM7 = 8'h12;

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        case (addr)
            8'h0A:   return 8'h76;
            8'h0B:   return 8'h73;
            8'h1C:   return 8'h7F;
            8'h1D:   return 8'hA2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_read_only(input logic [7:0] addr);
        return addr inside {8'h0A, 8'h0B, 8'h1C, 8'h1D};
    endfunction

    // [0],[1] form the synchronizer, [2] is the history flop used for edge detection.
    logic [2:0] sioc_q, siod_q;

    // NOTE: synchronizers reset to 1 so an idle (pulled-up) bus produces no false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_q <= '1;
            siod_q <= '1;
        end else begin
            sioc_q <= {sioc_q[1:0], sioc};
            siod_q <= {siod_q[1:0], siod_i};
        end
    end

    logic sioc_rise, sioc_fall, start_ev, stop_ev;
    assign sioc_rise = sioc_q[1] & ~sioc_q[2];
    assign sioc_fall = ~sioc_q[1] & sioc_q[2];
    assign start_ev  = sioc_q[1] & sioc_q[2] & siod_q[2] & ~siod_q[1];
    assign stop_ev   = sioc_q[1] & sioc_q[2] & ~siod_q[2] & siod_q[1];

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] tx;
    logic [7:0] ptr;
    logic       is_read;
    logic [7:0] regs [256];

    logic commit;
    assign commit = sioc_fall && (state == WDATA) && (bit_cnt == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tx         <= '0;
            ptr        <= '0;
            is_read    <= 1'b0;
            siod_oe    <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            soft_reset <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_strobe  <= 1'b0;
            soft_reset <= 1'b0;
            if (stop_ev) begin
                state   <= IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (start_ev) begin
                state   <= ID;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else begin
                // NOTE: rise and fall events are mutually exclusive, so bit_cnt has one writer per cycle.
                if (sioc_rise && (state inside {ID, SUB, WDATA})) begin
                    shift   <= {shift[6:0], siod_q[1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (sioc_fall) begin
                    case (state)
                        ID: if (bit_cnt == 4'd8) begin
                            if (shift[7:1] == DEV_ID[7:1]) begin
                                state   <= ID_ACK;
                                siod_oe <= 1'b1;
                                is_read <= shift[0];
                            end else begin
                                state   <= IGNORE;
                                siod_oe <= 1'b0;
                            end
                        end
                        ID_ACK: begin
                            if (is_read) begin
                                state   <= RDATA;
                                siod_oe <= ~regs[ptr][7];
                                tx      <= {regs[ptr][6:0], 1'b0};
                                bit_cnt <= 4'd1;
                            end else begin
                                state   <= SUB;
                                siod_oe <= 1'b0;
                                bit_cnt <= '0;
                            end
                        end
                        SUB: if (bit_cnt == 4'd8) begin
                            state   <= SUB_ACK;
                            siod_oe <= 1'b1;
                            ptr     <= shift;
                        end
                        SUB_ACK: begin
                            state   <= WDATA;
                            siod_oe <= 1'b0;
                            bit_cnt <= '0;
                        end
                        WDATA: if (bit_cnt == 4'd8) begin
                            state      <= WDATA_ACK;
                            siod_oe    <= 1'b1;
                            wr_strobe  <= 1'b1;
                            wr_addr    <= ptr;
                            wr_data    <= shift;
                            soft_reset <= (ptr == COM7) && shift[7];
                        end
                        WDATA_ACK: begin
                            state   <= IGNORE;
                            siod_oe <= 1'b0;
                        end
                        RDATA: begin
                            if (bit_cnt == 4'd8) begin
                                state   <= RNA;
                                siod_oe <= 1'b0;
                            end else begin
                                siod_oe <= ~tx[7];
                                tx      <= {tx[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        RNA: begin
                            state   <= IGNORE;
                            siod_oe <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // NOTE: the register file must reset to non-zero defaults, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
        end else if (commit) begin
            if ((ptr == COM7) && shift[7]) begin
                for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
            end else if (!is_read_only(ptr)) begin
                regs[ptr] <= shift;
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB master with an open-drain pad model.
module tb_sccb_responder;

    localparam int Q = 6;  // clk cycles per quarter SIOC period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sioc_drv = 1'b1;
    logic       siod_drv = 1'b1;
    logic       siod_pad;
    logic       siod_oe, wr_strobe, soft_reset, busy;
    logic [7:0] wr_addr, wr_data;

    int vectors = 0;
    int errors  = 0;

    int         strobe_cnt = 0, sr_cnt = 0, sr_with_strobe = 0, oe_cycles = 0;
    logic [7:0] last_addr = 8'h00, last_data = 8'h00;

    assign siod_pad = siod_drv & ~siod_oe;

    always #5 clk = ~clk;

    sccb_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sioc       (sioc_drv),
        .siod_i     (siod_pad),
        .siod_oe    (siod_oe),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .soft_reset (soft_reset),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            last_addr  <= wr_addr;
            last_data  <= wr_data;
        end
        if (soft_reset) sr_cnt <= sr_cnt + 1;
        if (soft_reset && wr_strobe) sr_with_strobe <= sr_with_strobe + 1;
        if (siod_oe) oe_cycles <= oe_cycles + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not end, time %0t limit 900000", $time);
        $fatal(1);
    end

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic sccb_start;
        siod_drv = 1'b1; wait_q(1);
        sioc_drv = 1'b1; wait_q(1);
        siod_drv = 1'b0; wait_q(1);
        sioc_drv = 1'b0; wait_q(1);
    endtask

    task automatic sccb_stop;
        siod_drv = 1'b0; wait_q(1);
        sioc_drv = 1'b1; wait_q(1);
        siod_drv = 1'b1; wait_q(2);
    endtask

    task automatic put_bits(input logic [7:0] b, input int n);
        logic [7:0] sr;
        sr = b;
        for (int i = 0; i < n; i++) begin
            siod_drv = sr[7]; wait_q(1);
            sioc_drv = 1'b1;  wait_q(2);
            sioc_drv = 1'b0;  wait_q(1);
            sr = {sr[6:0], 1'b0};
        end
    endtask

    // Master releases SIOD for one bit; returns 1 when the responder pulled it low.
    task automatic ack_bit(output logic ack);
        siod_drv = 1'b1; wait_q(1);
        sioc_drv = 1'b1; wait_q(1);
        ack = ~siod_pad; wait_q(1);
        sioc_drv = 1'b0; wait_q(1);
    endtask

    task automatic put_byte(input logic [7:0] b, output logic ack);
        put_bits(b, 8);
        ack_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] b, output logic na_released);
        logic bit_low;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ack_bit(bit_low);
            b = {b[6:0], ~bit_low};
        end
        ack_bit(bit_low);
        na_released = ~bit_low;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
        sccb_start;
        put_byte(8'h42, acks[2]);
        put_byte(a, acks[1]);
        put_byte(d, acks[0]);
        sccb_stop;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d, output logic [2:0] acks,
                            output logic na);
        sccb_start;
        put_byte(8'h42, acks[2]);
        put_byte(a, acks[1]);
        sccb_stop;
        sccb_start;
        put_byte(8'h43, acks[0]);
        get_byte(d, na);
        sccb_stop;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_q(1);
        vectors++; if (siod_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", siod_oe); end
        vectors++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", wr_strobe); end
        vectors++; if (soft_reset !== 1'b0) begin errors++; $display("FAIL rst_soft: got %b want 0", soft_reset); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", wr_addr); end
        vectors++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", wr_data); end
        rst_n = 1'b1;
        wait_q(1);
    endtask

    task automatic test_write;
        logic [2:0] acks;
        logic [7:0] d;
        logic       na;
        int         s0;
        s0 = strobe_cnt;
        sccb_start;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_on: got %b want 1", busy); end
        put_byte(8'h42, acks[2]);
        put_byte(8'h17, acks[1]);
        put_byte(8'h11, acks[0]);
        sccb_stop;
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL wr_acks: got %b want 111", acks); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_off: got %b want 0", busy); end
        vectors++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL wr_strobes: got %0d want 1", strobe_cnt - s0); end
        vectors++; if (last_addr !== 8'h17) begin errors++; $display("FAIL wr_addr: got %h want 17", last_addr); end
        vectors++; if (last_data !== 8'h11) begin errors++; $display("FAIL wr_data: got %h want 11", last_data); end
        read_reg(8'h17, d, acks, na);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL rd17_acks: got %b want 111", acks); end
        vectors++; if (d !== 8'h11) begin errors++; $display("FAIL rd17_data: got %h want 11", d); end
        vectors++; if (na !== 1'b1) begin errors++; $display("FAIL rd17_na: got %b want 1", na); end
    endtask

    task automatic test_read_only;
        logic [2:0] acks;
        logic [7:0] d;
        logic       na;
        int         s0;
        read_reg(8'h0A, d, acks, na);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL pid_acks: got %b want 111", acks); end
        vectors++; if (d !== 8'h76) begin errors++; $display("FAIL pid_data: got %h want 76", d); end
        vectors++; if (na !== 1'b1) begin errors++; $display("FAIL pid_na: got %b want 1", na); end
        s0 = strobe_cnt;
        write_reg(8'h0A, 8'h00, acks);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL ro_acks: got %b want 111", acks); end
        vectors++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL ro_strobes: got %0d want 1", strobe_cnt - s0); end
        vectors++; if (last_addr !== 8'h0A) begin errors++; $display("FAIL ro_addr: got %h want 0a", last_addr); end
        read_reg(8'h0A, d, acks, na);
        vectors++; if (d !== 8'h76) begin errors++; $display("FAIL ro_keep: got %h want 76", d); end
        read_reg(8'h1D, d, acks, na);
        vectors++; if (d !== 8'hA2) begin errors++; $display("FAIL midl_data: got %h want a2", d); end
    endtask

    task automatic test_bad_id;
        logic ack0, ack1;
        int   s0, o0;
        s0 = strobe_cnt;
        o0 = oe_cycles;
        sccb_start;
        put_byte(8'h60, ack0);
        put_byte(8'h17, ack1);
        sccb_stop;
        vectors++; if (ack0 !== 1'b0) begin errors++; $display("FAIL badid_ack: got %b want 0", ack0); end
        vectors++; if (ack1 !== 1'b0) begin errors++; $display("FAIL badid_ack2: got %b want 0", ack1); end
        vectors++; if (oe_cycles != o0) begin errors++; $display("FAIL badid_oe: got %0d oe cycles want 0", oe_cycles - o0); end
        vectors++; if (strobe_cnt != s0) begin errors++; $display("FAIL badid_strobe: got %0d want 0", strobe_cnt - s0); end
    endtask

    task automatic test_soft_reset;
        logic [2:0] acks;
        logic [7:0] d;
        logic       na;
        int         s0, r0, w0;
        write_reg(8'h40, 8'h55, acks);
        read_reg(8'h40, d, acks, na);
        vectors++; if (d !== 8'h55) begin errors++; $display("FAIL sr_pre40: got %h want 55", d); end
        s0 = strobe_cnt; r0 = sr_cnt; w0 = sr_with_strobe;
        write_reg(8'h12, 8'h80, acks);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL sr_acks: got %b want 111", acks); end
        vectors++; if (sr_cnt - r0 != 1) begin errors++; $display("FAIL sr_pulses: got %0d want 1", sr_cnt - r0); end
        vectors++; if (sr_with_strobe - w0 != 1) begin errors++; $display("FAIL sr_coincide: got %0d want 1", sr_with_strobe - w0); end
        vectors++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL sr_strobes: got %0d want 1", strobe_cnt - s0); end
        read_reg(8'h40, d, acks, na);
        vectors++; if (d !== 8'h00) begin errors++; $display("FAIL sr_post40: got %h want 00", d); end
        read_reg(8'h12, d, acks, na);
        vectors++; if (d !== 8'h00) begin errors++; $display("FAIL sr_post12: got %h want 00", d); end
        read_reg(8'h0B, d, acks, na);
        vectors++; if (d !== 8'h73) begin errors++; $display("FAIL sr_ver: got %h want 73", d); end
    endtask

    task automatic test_repeated_start;
        logic [2:0] acks;
        logic [7:0] d;
        logic       na, a0, a1, a2;
        int         s0;
        write_reg(8'h20, 8'h5A, acks);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL rs_setup: got %b want 111", acks); end
        s0 = strobe_cnt;
        sccb_start;
        put_byte(8'h42, a0);
        put_byte(8'h20, a1);
        put_bits(8'hC3, 4);
        sccb_start;
        put_byte(8'h43, a2);
        get_byte(d, na);
        sccb_stop;
        vectors++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rs_acks: got %b want 111", {a0, a1, a2}); end
        vectors++; if (strobe_cnt != s0) begin errors++; $display("FAIL rs_nocommit: got %0d strobes want 0", strobe_cnt - s0); end
        vectors++; if (d !== 8'h5A) begin errors++; $display("FAIL rs_data: got %h want 5a", d); end
        vectors++; if (na !== 1'b1) begin errors++; $display("FAIL rs_na: got %b want 1", na); end
    endtask

    task automatic test_reset_mid_ack;
        logic [2:0] acks;
        logic [7:0] d;
        logic       na, a0, a1;
        int         s0, o0;
        sccb_start;
        put_bits(8'h42, 8);
        vectors++; if (siod_oe !== 1'b1) begin errors++; $display("FAIL mid_ack_on: got %b want 1", siod_oe); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (siod_oe !== 1'b0) begin errors++; $display("FAIL mid_async_oe: got %b want 0", siod_oe); end
        vectors++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_addr: got %h want 00", wr_addr); end
        @(negedge clk) rst_n = 1'b1;
        s0 = strobe_cnt;
        o0 = oe_cycles;
        ack_bit(a0);
        put_byte(8'h30, a1);
        sccb_stop;
        vectors++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL mid_ignored: got %b want 00", {a0, a1}); end
        vectors++; if (oe_cycles != o0) begin errors++; $display("FAIL mid_oe_quiet: got %0d oe cycles want 0", oe_cycles - o0); end
        write_reg(8'h30, 8'h99, acks);
        vectors++; if (acks !== 3'b111) begin errors++; $display("FAIL post_acks: got %b want 111", acks); end
        vectors++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL post_strobes: got %0d want 1", strobe_cnt - s0); end
        vectors++; if (last_data !== 8'h99) begin errors++; $display("FAIL post_data: got %h want 99", last_data); end
        read_reg(8'h20, d, acks, na);
        vectors++; if (d !== 8'h00) begin errors++; $display("FAIL post_rf_default: got %h want 00", d); end
        read_reg(8'h30, d, acks, na);
        vectors++; if (d !== 8'h99) begin errors++; $display("FAIL post_rd30: got %h want 99", d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_only();
        test_bad_id();
        test_soft_reset();
        test_repeated_start();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
